// File: rtl/ips2l_seu_uart_pkg.sv
// Shared definitions for the SEU debug UART (transmitter now, receiver later).
// IPS2L_SEU_UART_TX_TWO_STOP_EN adds the STOP2 state to the encoding.
package ips2l_seu_uart_pkg;

  localparam int UART_DATA_W         = 8;
  localparam int UART_OVERSAMPLE_DEF = 6;
  localparam int UART_TICK_W         = 4;
  localparam int UART_BIT_CNT_W      = 3;

`ifdef IPS2L_SEU_UART_TX_TWO_STOP_EN
  localparam int UART_ST_W = 3;
`else
  localparam int UART_ST_W = 2;
`endif

  localparam logic [UART_ST_W-1:0] ST_IDLE  = UART_ST_W'(0);
  localparam logic [UART_ST_W-1:0] ST_START = UART_ST_W'(1);
  localparam logic [UART_ST_W-1:0] ST_DATA  = UART_ST_W'(2);
  localparam logic [UART_ST_W-1:0] ST_STOP  = UART_ST_W'(3);
`ifdef IPS2L_SEU_UART_TX_TWO_STOP_EN
  localparam logic [UART_ST_W-1:0] ST_STOP2 = UART_ST_W'(4);
`endif

endpackage

// File: rtl/ips2l_seu_uart_bit_timer.sv
// Oversample tick counter: counts 0..OVERSAMPLE-1 on clk_en, flags the last
// tick of each bit period. clr holds it at zero (used while the line is idle).
module ips2l_seu_uart_bit_timer
  import ips2l_seu_uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_en,
  input  logic clr,
  output logic bit_end
);

  localparam logic [UART_TICK_W-1:0] TICK_LAST = UART_TICK_W'(OVERSAMPLE - 1);

  logic [UART_TICK_W-1:0] tick_cnt_q;
  logic [UART_TICK_W-1:0] tick_cnt_d;

  assign bit_end = clk_en && (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (clr) begin
      tick_cnt_d = '0;
    end else if (clk_en) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + UART_TICK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule

// File: rtl/ips2l_seu_uart_tx.sv
// SEU debug UART transmitter: pops bytes from a FWFT FIFO and sends 8N1 frames
// (8N2 when IPS2L_SEU_UART_TX_TWO_STOP_EN is defined), timed by clk_en ticks.
module ips2l_seu_uart_tx
  import ips2l_seu_uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic [UART_DATA_W-1:0] tx_fifo_rd_data,
  input  logic                   tx_fifo_rd_data_valid,
  output logic                   tx_fifo_rd_data_req,
  output logic                   tx_busy,
  output logic                   txd
);

`ifdef IPS2L_SEU_UART_TX_TWO_STOP_EN
  localparam logic [UART_ST_W-1:0] ST_LAST_STOP = ST_STOP2;
`else
  localparam logic [UART_ST_W-1:0] ST_LAST_STOP = ST_STOP;
`endif

  logic [UART_ST_W-1:0]      state_q, state_d;
  logic [UART_DATA_W-1:0]    shift_q, shift_d;
  logic [UART_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                      txd_q, txd_d;
  logic                      bit_end;
  logic                      pop;

  ips2l_seu_uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_en  (clk_en),
    .clr     (state_q == ST_IDLE),
    .bit_end (bit_end)
  );

  // FIFO handshake: FWFT head is valid while tx_fifo_rd_data_valid is high;
  // tx_fifo_rd_data_req is a one-cycle pop, only asserted with clk_en and
  // valid, on the same edge that latches the head byte into shift_q.
  always_comb begin
    pop = 1'b0;
    if (clk_en && tx_fifo_rd_data_valid) begin
      pop = (state_q == ST_IDLE) || (state_q == ST_LAST_STOP && bit_end);
    end
  end

  assign tx_fifo_rd_data_req = pop;
  assign tx_busy             = (state_q != ST_IDLE);
  assign txd                 = txd_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    txd_d     = txd_q;
    case (state_q)
      ST_IDLE: ;
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          txd_d     = shift_q[0];
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + UART_BIT_CNT_W'(1);
          if (bit_cnt_q == UART_BIT_CNT_W'(7)) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            txd_d   = shift_q[1];
          end
        end
      end
`ifdef IPS2L_SEU_UART_TX_TWO_STOP_EN
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_STOP2;
          txd_d   = 1'b1;
        end
      end
`endif
      ST_LAST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pop always starts a new frame, whether from IDLE or back-to-back.
    if (pop) begin
      shift_d = tx_fifo_rd_data;
      state_d = ST_START;
      txd_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
    end
  end

endmodule

// File: doc/ips2l_seu_uart_tx.md
# ips2l_seu_uart_tx

Byte-serialising UART transmitter for the SEU monitor's debug UART. It pops bytes from a first-word-fall-through TX FIFO and shifts each one out on `txd` as start bit, 8 data bits LSB first, then stop bit(s). Bit timing comes from the shared `clk_en` oversample tick, the same one that drives the SEU UART receiver. A frame sent here is therefore decoded bit-exactly by the receiver on the other end of the link.

## Interface
- `OVERSAMPLE`, default 6: number of `clk_en` ticks per bit period. Legal range 2..15.
- `clk` input, 1 bit: single system clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `clk_en` input, 1 bit: single-`clk` oversample tick. All state advances only on cycles where it is high.
- `tx_fifo_rd_data` input, 8 bits: FIFO head byte. Valid whenever `tx_fifo_rd_data_valid` is high.
- `tx_fifo_rd_data_valid` input, 1 bit: FIFO not empty.
- `tx_fifo_rd_data_req` output, 1 bit: pop strobe, one `clk` cycle wide.
- `tx_busy` output, 1 bit: a frame is in progress.
- `txd` output, 1 bit: serial line. Registered, idle high.

## Operation
- States:
  - IDLE → START → DATA → STOP, then back to IDLE.
  - With the configuration macro defined: IDLE → START → DATA → STOP → STOP2 → IDLE.
- Bit timer: `tick_cnt` counts 0..OVERSAMPLE-1 on `clk_en`. `bit_end` = `clk_en` && `tick_cnt`==OVERSAMPLE-1. The timer clears in IDLE.
- IDLE:
  - On a `clk_en` cycle with `tx_fifo_rd_data_valid`=1, pulse `tx_fifo_rd_data_req` and latch `tx_fifo_rd_data` into `shift_reg`.
  - On the same edge, go to START and drive `txd`<=0.
- START: on `bit_end`, go to DATA, drive `txd`<=`shift_reg[0]`, set `bit_cnt`=0.
- DATA:
  - On each `bit_end`, shift `shift_reg` right and increment `bit_cnt`.
  - Drive `txd`<=next LSB.
  - After the bit with `bit_cnt`==7 ends, go to STOP and drive `txd`<=1.
- STOP, final stop state: on `bit_end`:
  - If `tx_fifo_rd_data_valid`=1: pulse `tx_fifo_rd_data_req`, latch the byte, go straight to START and drive `txd`<=0. There is no idle gap between frames.
  - Otherwise go to IDLE.
- `tx_busy` is high in every state except IDLE.
- Width rules: `bit_cnt` is 3 bits, and its wrap from 7 is never used. `tick_cnt` is 4 bits.
- Boundary conditions:
  - `tx_fifo_rd_data_valid` falling mid-frame has no effect, because the byte is already latched.
  - `clk_en` low freezes all state. `txd` holds its value.
  - `tx_fifo_rd_data_req` is only ever asserted together with `clk_en`. It is never asserted while `tx_fifo_rd_data_valid`=0.
  - Reset mid-frame: `txd` goes to 1 asynchronously, the FSM returns to IDLE, and the partially sent byte is dropped. The receiver sees a truncated frame. No recovery action is required here.

## Timing
- Reset values: `txd`=1, `tx_fifo_rd_data_req`=0, `tx_busy`=0. Internally `shift_reg`=0, `tick_cnt`=0, `bit_cnt`=0, state IDLE.
- Latency: `txd` falls one `clk` after the `clk_en` edge on which IDLE sees `tx_fifo_rd_data_valid`. The pop pulse is asserted on that same edge.
- Each bit lasts exactly OVERSAMPLE `clk_en` ticks.
- Frame length is 10×OVERSAMPLE ticks, or 11×OVERSAMPLE with the configuration macro defined.
- Sustained throughput is one byte per frame length. The FIFO is popped once per frame.

## Configuration
- Macro: `IPS2L_SEU_UART_TX_TWO_STOP_EN`.
- Defined: STOP2 is compiled in. Every frame carries two stop bits, each OVERSAMPLE ticks long. The back-to-back pop decision moves to the end of STOP2.
- Undefined: one stop bit. STOP2 is absent from the state encoding.
- Both modes are receivable by the SEU UART receiver.

## Structure
- Package `ips2l_seu_uart_pkg` holds:
  - the FSM state encoding (IDLE, START, DATA, STOP, STOP2);
  - `UART_DATA_W`=8;
  - `UART_OVERSAMPLE_DEF`=6.
- The receiver is to be migrated to the same package.
- One sub-module, `ips2l_seu_uart_bit_timer`: an OVERSAMPLE tick counter with clear input and `bit_end` output. It is reusable by the receiver.

## Test plan
- OVERSAMPLE=6, FIFO holds 0x55 → one `tx_fifo_rd_data_req` pulse. `txd` per 6-tick bit: 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), then idle high. `tx_busy` is high for exactly 60 ticks.
- FIFO holds 0xA3 and 0x0F back-to-back → two pulses 60 ticks apart. The second frame's start bit begins immediately after the first stop bit, with no gap.
- `clk_en` held low for 20 cycles mid-DATA → `txd` and all counters frozen. The frame completes with the correct bit widths once ticks resume.
- `rst_n` asserted during the fourth data bit of 0xFF → `txd`=1 immediately, `tx_busy`=0. After release, no pop occurs until `tx_fifo_rd_data_valid` is presented again.
- With `IPS2L_SEU_UART_TX_TWO_STOP_EN`, send 0x00 → `txd` low for 54 ticks, then high for 12 ticks, then the next pop. Frame length is 66 ticks.
- Loopback to the SEU UART receiver, 256 bytes 0x00..0xFF back-to-back → every byte received in order with matching value.
